// File: rtl/l2_cache_ctrl.sv
// ============================================================================
// Module   : l2_cache_ctrl
// Summary  : Single-ported L2 lookup/fill controller. It handles read hits and
//            read-miss fills, and uses write-through, no-allocate writes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_cache_ctrl #(
    parameter int BLOCK_SIZE = 128,
    parameter int TAG_SIZE   = 7,
    parameter int IDX_SIZE   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [TAG_SIZE+IDX_SIZE-1:0] req_addr_i,
    input  logic                         req_we_i,
    input  logic [BLOCK_SIZE-1:0]        req_wdata_i,
    input  logic [BLOCK_SIZE/8-1:0]      req_be_i,

    output logic                         resp_valid_o,
    output logic [BLOCK_SIZE-1:0]        resp_data_o,
    output logic                         resp_hit_o,

    output logic [TAG_SIZE+IDX_SIZE-1:0] arr_tag_and_idx_o,
    output logic                         arr_we_o,
    output logic [BLOCK_SIZE/8-1:0]      arr_be_o,
    output logic [BLOCK_SIZE-1:0]        arr_block_o,
    input  logic [BLOCK_SIZE-1:0]        arr_block_i,
    input  logic                         arr_valid_i,
    input  logic [TAG_SIZE-1:0]          arr_tag_i,

    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [TAG_SIZE+IDX_SIZE-1:0] mem_addr_o,
    output logic                         mem_we_o,
    output logic [BLOCK_SIZE-1:0]        mem_wdata_o,
    output logic [BLOCK_SIZE/8-1:0]      mem_be_o,
    input  logic                         mem_resp_valid_i,
    input  logic [BLOCK_SIZE-1:0]        mem_resp_data_i,

    output logic [15:0]                  hit_cnt_o,
    output logic [15:0]                  miss_cnt_o
);

    localparam int ADDR_W = TAG_SIZE + IDX_SIZE;
    localparam int BE_W   = BLOCK_SIZE / 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_COMPARE  = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_FILL     = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [BLOCK_SIZE-1:0] r_block;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic                  r_mem_req_valid;
    logic [15:0]           r_hit_cnt;
    logic [15:0]           r_miss_cnt;

    logic [TAG_SIZE-1:0]   w_cap_tag;
    logic                  w_hit;
    logic                  w_arr_wr_hit;
    logic                  w_fill;

    assign w_cap_tag    = r_addr[ADDR_W-1:IDX_SIZE];
    assign w_hit        = arr_valid_i && (arr_tag_i == w_cap_tag);
    assign w_arr_wr_hit = (r_state == S_COMPARE) && r_we && w_hit;
    assign w_fill       = (r_state == S_FILL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_be            <= '0;
            r_block         <= '0;
            r_req_ready     <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_hit_cnt       <= 16'd0;
            r_miss_cnt      <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid_i) begin
                        r_addr      <= req_addr_i;
                        r_we        <= req_we_i;
                        r_wdata     <= req_wdata_i;
                        r_be        <= req_be_i;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_COMPARE;
                end
                S_COMPARE: begin
                    r_resp_hit <= w_hit;
                    if (w_hit) begin
                        if (r_hit_cnt != 16'hFFFF) begin
                            r_hit_cnt <= r_hit_cnt + 16'd1;
                        end
                    end else if (r_miss_cnt != 16'hFFFF) begin
                        r_miss_cnt <= r_miss_cnt + 16'd1;
                    end
                    if (w_hit && !r_we) begin
                        r_block      <= arr_block_i;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_we) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid_i) begin
                        r_block <= mem_resp_data_i;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid    <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = r_req_ready;
    assign resp_valid_o      = r_resp_valid;
    assign resp_data_o       = r_block;
    assign resp_hit_o        = r_resp_hit;

    // The array port only writes on a write hit (during COMPARE) or on a fill.
    assign arr_tag_and_idx_o = r_addr;
    assign arr_we_o          = w_arr_wr_hit || w_fill;
    assign arr_be_o          = w_fill ? {BE_W{1'b1}} : (w_arr_wr_hit ? r_be : '0);
    assign arr_block_o       = w_fill ? r_block : (w_arr_wr_hit ? r_wdata : '0);

    assign mem_req_valid_o   = r_mem_req_valid;
    assign mem_addr_o        = r_addr;
    assign mem_we_o          = r_we;
    assign mem_wdata_o       = r_wdata;
    assign mem_be_o          = r_be;

    assign hit_cnt_o         = r_hit_cnt;
    assign miss_cnt_o        = r_miss_cnt;

endmodule

`default_nettype wire

// File: doc/l2_cache_ctrl.md
L2_CACHE_CTRL -- requirements
Module: l2_cache_ctrl

Interface
REQ-001 Parameter BLOCK_SIZE, default 128: block width in bits; byte-enable width is BLOCK_SIZE/8.
REQ-002 Parameter TAG_SIZE, default 7: tag bits of the block address.
REQ-003 Parameter IDX_SIZE, default 8: index bits; array depth is 2^IDX_SIZE.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  clock; all state changes on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 req_valid_i / req_ready_o  in/out  1  L1 request handshake.
REQ-008 req_addr_i  in  TAG_SIZE+IDX_SIZE  block address, {tag,idx}.
REQ-009 req_we_i, req_wdata_i, req_be_i  in  1/BLOCK_SIZE/BLOCK_SIZE/8  write flag, write data, byte enables.
REQ-010 resp_valid_o, resp_data_o, resp_hit_o  out  1/BLOCK_SIZE/1  one-cycle response pulse, read data, hit flag.
REQ-011 arr_tag_and_idx_o, arr_we_o, arr_be_o, arr_block_o  out  TAG_SIZE+IDX_SIZE/1/BLOCK_SIZE/8/BLOCK_SIZE  port-1 drive of the L2 set.
REQ-012 arr_block_i, arr_valid_i, arr_tag_i  in  BLOCK_SIZE/1/TAG_SIZE  port-1 read-back; 1-cycle synchronous read latency.
REQ-013 mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
REQ-014 mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o  out  block address, write flag, data, byte enables.
REQ-015 mem_resp_valid_i, mem_resp_data_i  in  1/BLOCK_SIZE  read-fill return.
REQ-016 hit_cnt_o, miss_cnt_o  out  16  saturating counters of lookups.

Function
REQ-017 The block SHALL implement states IDLE, LOOKUP, COMPARE, MEM_REQ, MEM_WAIT, FILL and RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a request SHALL be captured into registers on valid&&ready, then IDLE->LOOKUP.
REQ-019 LOOKUP SHALL drive arr_tag_and_idx_o with the captured address and arr_we_o=0, then go to COMPARE.
REQ-020 In COMPARE, hit SHALL be arr_valid_i && (arr_tag_i == captured tag).
REQ-021 Read hit: arr_block_i SHALL be latched, resp_hit_o set to 1, hit_cnt incremented; COMPARE->RESP.
REQ-022 Read miss: miss_cnt SHALL be incremented; COMPARE->MEM_REQ with mem_we_o=0.
REQ-023 Write hit: arr_we_o=1, arr_be_o=req_be, arr_block_o=req_wdata SHALL be driven during the COMPARE cycle; hit_cnt incremented; COMPARE->MEM_REQ.
REQ-024 Write miss: array SHALL NOT be written (no-allocate); miss_cnt incremented; COMPARE->MEM_REQ.
REQ-025 Writes SHALL be write-through: MEM_REQ presents mem_we_o=1 with captured data and byte enables.
REQ-026 MEM_REQ SHALL hold mem_req_valid_o=1 and all mem_* outputs stable until mem_req_ready_i=1; then read->MEM_WAIT, write->RESP.
REQ-027 MEM_WAIT SHALL latch mem_resp_data_i on mem_resp_valid_i, then go to FILL; mem_resp_valid_i in any other state SHALL be ignored.
REQ-028 FILL SHALL write the latched block with arr_we_o=1 and all byte enables set, then go to RESP with resp_hit_o=0.
REQ-029 RESP SHALL assert resp_valid_o for exactly one cycle; resp_data_o is valid for reads only; then RESP->IDLE.
REQ-030 Read-hit latency SHALL be 3 cycles from the accepting edge to resp_valid_o; read-miss latency SHALL be 5 cycles plus memory wait cycles.
REQ-031 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-032 arr_we_o SHALL be 0 in every state other than COMPARE-on-write-hit and FILL.

Reset
REQ-033 Asserting rst_ni low SHALL immediately force IDLE, clear all captured registers and counters, and drive every output to 0, except req_ready_o, which SHALL be 1 while in IDLE after release.
REQ-034 Reset mid-transaction SHALL abandon the pending memory transaction without issuing an array write; array contents are not cleared by this block.

Verification
REQ-035 Preload idx 5 with valid=1, tag 3, data A; read addr {3,5} -> resp_valid 3 cycles later, resp_hit_o=1, data A, hit_cnt=1.
REQ-036 Read {4,5} with memory returning B after 2 waits -> mem_addr {4,5}; FILL writes B with be=FFFF; resp_hit_o=0; re-read hits B.
REQ-037 Write {3,5} with be=0x000F -> array low 4 bytes updated, mem_we_o=1, same be; a write miss leaves the array unchanged.
REQ-038 Hold mem_req_ready_i=0 for 10 cycles -> mem_* outputs stable, req_ready_o=0, no response.
REQ-039 Assert rst_ni in MEM_WAIT, then deliver mem_resp_valid_i -> no FILL write, state IDLE, counters 0.
REQ-040 Force hit_cnt to 16'hFFFF, then issue a hit -> value stays 16'hFFFF.
